// File: rtl/ddr3_frame_writer_pkg.sv
// Shared widths, limits, FSM encoding and small helpers for the DDR3 frame writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wps_pkg;

    localparam int DATA_W         = 256;
    localparam int BE_W           = DATA_W / 8;
    localparam int ADDR_W         = 22;
    localparam int BURST_W        = 5;
    localparam int MAX_BURST      = 16;
    localparam int FIFO_DEPTH     = 32;
    localparam int BYTES_PER_WORD = 32;
    localparam int WCNT_W         = 27;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_BURST,
        ST_DONE
    } wr_state_t;

    // ceil(bytes / 32) without a wide adder: whole words plus one for any tail.
    function automatic logic [WCNT_W-1:0] words_for_bytes(input logic [31:0] bytes);
        return WCNT_W'(bytes[31:5]) + WCNT_W'(|bytes[4:0]);
    endfunction

    // Byte enables for the final word of a transfer; r = bytes mod 32.
    function automatic logic [BE_W-1:0] tail_mask(input logic [4:0] r);
        logic [BE_W-1:0] m;
        m = '1;
        if (r != 5'd0) begin
            m = ~({BE_W{1'b1}} << r);
        end
        return m;
    endfunction

endpackage

// File: rtl/ddr3_frame_writer_if.sv
// Frame stream input plus Avalon-MM EMIF write port of the DDR3 frame writer.
// Latency: n/a (wires only).
// Backpressure: s_valid/s_ready on the stream, ddr3_emif_ready holds the EMIF side.
// Ports: master = writer view, slave = host loader / EMIF view.
interface ddr3_frame_writer_if;
    import wps_pkg::*;

    logic [DATA_W-1:0]  s_data;
    logic               s_valid;
    logic               s_ready;

    logic               ddr3_emif_ready;
    logic               ddr3_emif_write;
    logic [ADDR_W-1:0]  ddr3_emif_addr;
    logic [DATA_W-1:0]  ddr3_emif_write_data;
    logic [BE_W-1:0]    ddr3_emif_byte_enable;
    logic [BURST_W-1:0] ddr3_emif_burst_count;

    modport master (
        input  s_data, s_valid, ddr3_emif_ready,
        output s_ready, ddr3_emif_write, ddr3_emif_addr, ddr3_emif_write_data,
               ddr3_emif_byte_enable, ddr3_emif_burst_count
    );

    modport slave (
        output s_data, s_valid, ddr3_emif_ready,
        input  s_ready, ddr3_emif_write, ddr3_emif_addr, ddr3_emif_write_data,
               ddr3_emif_byte_enable, ddr3_emif_burst_count
    );
endinterface

// File: rtl/ddr3_frame_writer_fifo.sv
// Single-clock first-word-fall-through FIFO with exact full/empty and a level count.
// Latency: a pushed word is visible on head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop keeps level.
// Ports: push/push_data in, pop in, head/full/empty/level out.
module sync_fifo_fwft #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ddr3_frame_writer.sv
// Buffers 256-bit frame words and writes them to DDR3 as Avalon-MM bursts of up to 16 beats.
// Latency: first beat 1 cycle after a full burst is buffered; 1 beat/clk while ready is high.
// Backpressure: s_ready drops on FIFO full or word total reached; ddr3_emif_ready=0 holds the beat.
// Ports: clk/rst_n, start_in/start_addr_in/to_write_byte_in, busy_out/done_out, bus (stream + EMIF).
module ddr3_frame_writer
    import wps_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_in,
    input  logic [ADDR_W-1:0]          start_addr_in,
    input  logic [31:0]                to_write_byte_in,
    output logic                       busy_out,
    output logic                       done_out,
    ddr3_frame_writer_if.master        bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    wr_state_t          state;
    logic [ADDR_W-1:0]  addr_q;
    logic [WCNT_W-1:0]  total_words;
    logic [WCNT_W-1:0]  remaining;
    logic [WCNT_W-1:0]  accepted;
    logic [4:0]         tail_bytes;
    logic [BURST_W-1:0] beats_left;
    logic [BURST_W-1:0] burst_len;
    logic               write_q;
    logic [ADDR_W-1:0]  emif_addr_q;
    logic [BURST_W-1:0] emif_count_q;

    logic [DATA_W-1:0]  fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_level;

    logic               s_ready_int;
    logic               push;
    logic               pop;
    logic               beat_done;
    logic               last_word;

    // remaining only changes at the end of a burst, so this stays valid through it.
    always_comb begin
        burst_len = BURST_W'(remaining);
        if (remaining >= WCNT_W'(MAX_BURST)) burst_len = BURST_W'(MAX_BURST);
    end

    assign s_ready_int = (state != ST_IDLE) && !fifo_full && (accepted < total_words);
    assign push        = bus.s_valid && s_ready_int;
    assign beat_done   = write_q && bus.ddr3_emif_ready;
    assign pop         = beat_done && !fifo_empty;
    assign last_word   = (remaining == WCNT_W'(burst_len)) && (beats_left == BURST_W'(1));

    sync_fifo_fwft #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.s_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign bus.s_ready               = s_ready_int;
    assign bus.ddr3_emif_write       = write_q;
    assign bus.ddr3_emif_addr        = emif_addr_q;
    assign bus.ddr3_emif_burst_count = emif_count_q;
    // Data and enables are forced to zero outside a beat so idle outputs stay clean.
    assign bus.ddr3_emif_write_data  = write_q ? fifo_head : '0;
    assign bus.ddr3_emif_byte_enable = !write_q ? '0 :
                                       last_word ? tail_mask(tail_bytes) : '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            total_words  <= '0;
            remaining    <= '0;
            accepted     <= '0;
            tail_bytes   <= '0;
            beats_left   <= '0;
            write_q      <= 1'b0;
            emif_addr_q  <= '0;
            emif_count_q <= '0;
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
        end else begin
            done_out <= 1'b0;
            if (push) accepted <= accepted + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        addr_q      <= start_addr_in;
                        total_words <= words_for_bytes(to_write_byte_in);
                        remaining   <= words_for_bytes(to_write_byte_in);
                        tail_bytes  <= to_write_byte_in[4:0];
                        accepted    <= '0;
                        if (to_write_byte_in == 32'd0) begin
                            state    <= ST_DONE;
                            done_out <= 1'b1;
                        end else begin
                            state    <= ST_WAIT_DATA;
                            busy_out <= 1'b1;
                        end
                    end
                end

                ST_WAIT_DATA: begin
                    // Whole burst must be buffered: EMIF bursts cannot stall on our side.
                    if (fifo_level >= LVL_W'(burst_len)) begin
                        state        <= ST_BURST;
                        write_q      <= 1'b1;
                        emif_addr_q  <= addr_q;
                        emif_count_q <= burst_len;
                        beats_left   <= burst_len;
                    end
                end

                ST_BURST: begin
                    if (beat_done) begin
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == BURST_W'(1)) begin
                            write_q      <= 1'b0;
                            emif_addr_q  <= '0;
                            emif_count_q <= '0;
                            addr_q       <= addr_q + ADDR_W'(burst_len);
                            remaining    <= remaining - WCNT_W'(burst_len);
                            if (remaining == WCNT_W'(burst_len)) begin
                                state    <= ST_DONE;
                                busy_out <= 1'b0;
                                done_out <= 1'b1;
                            end else begin
                                state <= ST_WAIT_DATA;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_frame_writer.sv
module tb_ddr3_frame_writer;
    import wps_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_in = 1'b0;
    logic [ADDR_W-1:0] start_addr_in = '0;
    logic [31:0]       to_write_byte_in = '0;
    logic              busy_out;
    logic              done_out;

    ddr3_frame_writer_if bus();

    ddr3_frame_writer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_in         (start_in),
        .start_addr_in    (start_addr_in),
        .to_write_byte_in (to_write_byte_in),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .bus              (bus)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: expected bursts, per-beat enables, accepted word data.
    logic [255:0] exp_data [$];
    logic [31:0]  exp_be [$];
    int           exp_baddr [$];
    int           exp_bcnt [$];
    int           done_pending = 0;
    int           acc_cnt = 0;
    int           acc_total = 0;

    // Observations used by literal pins.
    int           obs_addr [$];
    int           obs_cnt [$];
    logic [31:0]  last_be = '0;
    int           beats_seen = 0;
    int           dones_seen = 0;

    // Stimulus controls.
    bit           src_en = 0;
    int           offered = 0;
    int           offer_limit = 0;
    int           vprob = 100;
    int           rmode = 0;
    int           rcyc = 0;
    bit           hs_seen = 0;

    task automatic plan(input int addr, input longint unsigned bytes);
        longint unsigned total;
        int r;
        int a;
        longint unsigned rem;
        int n;
        total = (bytes + 31) / 32;
        r = int'(bytes % 32);
        a = addr;
        rem = total;
        while (rem > 0) begin
            n = (rem > 16) ? 16 : int'(rem);
            exp_baddr.push_back(a);
            exp_bcnt.push_back(n);
            a = (a + n) % (1 << 22);
            rem -= n;
        end
        for (longint unsigned i = 0; i < total; i++) begin
            if (i == total - 1 && r != 0) exp_be.push_back((32'd1 << r) - 32'd1);
            else                          exp_be.push_back(32'hFFFF_FFFF);
        end
        acc_total = int'(total);
        acc_cnt = 0;
        done_pending++;
    endtask

    task automatic flush_model();
        exp_data.delete();
        exp_be.delete();
        exp_baddr.delete();
        exp_bcnt.delete();
        done_pending = 0;
        acc_cnt = 0;
        acc_total = 0;
    endtask

    // Source: holds a word until accepted, new random word afterwards.
    initial forever begin
        @(posedge clk);
        #1;
        if (bus.s_valid && hs_seen) begin
            bus.s_valid = 1'b0;
            offered++;
        end
        if (!src_en) begin
            bus.s_valid = 1'b0;
        end else if (!bus.s_valid && offered < offer_limit && int'($urandom % 100) < vprob) begin
            bus.s_valid = 1'b1;
            for (int i = 0; i < 8; i++) bus.s_data[i*32 +: 32] = $urandom;
        end
    end

    // EMIF ready driver.
    initial forever begin
        @(posedge clk);
        #1;
        rcyc++;
        case (rmode)
            0:       bus.ddr3_emif_ready = 1'b1;
            1:       bus.ddr3_emif_ready = ((rcyc / 3) % 2) == 0;
            default: bus.ddr3_emif_ready = ($urandom % 4) != 0;
        endcase
    end

    // Compare process, sampling on the falling edge.
    int           mon_left = 0;
    bit           stall = 0;
    bit           ended = 0;
    logic [21:0]  snap_addr;
    logic [4:0]   snap_cnt;
    logic [255:0] snap_data;
    logic [31:0]  snap_be;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_left = 0;
            stall = 0;
            ended = 0;
            hs_seen = 0;
        end else begin
            hs_seen = bus.s_valid && bus.s_ready;
            if (bus.s_valid && acc_cnt >= acc_total) chk("s_ready_past_total", bus.s_ready, 0);
            if (hs_seen) begin
                exp_data.push_back(bus.s_data);
                acc_cnt++;
            end
            if (ended) chk("write_gap_between_bursts", bus.ddr3_emif_write, 0);
            ended = 0;
            if (mon_left > 0) chk("write_held_in_burst", bus.ddr3_emif_write, 1);
            if (stall) begin
                chk("hold_addr", bus.ddr3_emif_addr, snap_addr);
                chk("hold_count", bus.ddr3_emif_burst_count, snap_cnt);
                chk("hold_data", bus.ddr3_emif_write_data, snap_data);
                chk("hold_be", bus.ddr3_emif_byte_enable, snap_be);
            end
            stall = 0;
            if (bus.ddr3_emif_write) begin
                if (mon_left == 0) begin
                    if (exp_baddr.size() == 0) begin
                        chk("unexpected_burst", 1, 0);
                    end else begin
                        chk("burst_addr", bus.ddr3_emif_addr, exp_baddr[0]);
                        chk("burst_count", bus.ddr3_emif_burst_count, exp_bcnt[0]);
                        mon_left = exp_bcnt[0];
                        obs_addr.push_back(int'(bus.ddr3_emif_addr));
                        obs_cnt.push_back(int'(bus.ddr3_emif_burst_count));
                        void'(exp_baddr.pop_front());
                        void'(exp_bcnt.pop_front());
                    end
                end
                if (bus.ddr3_emif_ready) begin
                    if (exp_data.size() == 0) chk("beat_without_input_word", 1, 0);
                    else chk("beat_data", bus.ddr3_emif_write_data, exp_data.pop_front());
                    if (exp_be.size() == 0) chk("beat_without_expectation", 1, 0);
                    else chk("beat_be", bus.ddr3_emif_byte_enable, exp_be.pop_front());
                    last_be = bus.ddr3_emif_byte_enable;
                    beats_seen++;
                    if (mon_left > 0) begin
                        mon_left--;
                        if (mon_left == 0) ended = 1;
                    end
                end else begin
                    stall = 1;
                    snap_addr = bus.ddr3_emif_addr;
                    snap_cnt = bus.ddr3_emif_burst_count;
                    snap_data = bus.ddr3_emif_write_data;
                    snap_be = bus.ddr3_emif_byte_enable;
                end
            end
            if (done_out) begin
                chk("done_expected", done_pending > 0, 1);
                chk("done_after_all_beats", exp_be.size(), 0);
                chk("done_no_pending_burst", exp_baddr.size(), 0);
                chk("busy_low_at_done", busy_out, 0);
                if (done_pending > 0) done_pending--;
                dones_seen++;
            end
        end
    end

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (dones_seen == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen_in_budget", dones_seen > 0, 1);
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_cnt.delete();
        beats_seen = 0;
        dones_seen = 0;
    endtask

    task automatic run_xfer(input int a, input int unsigned b, input int offer, input int rm, input int vp);
        clear_obs();
        rmode = rm;
        vprob = vp;
        offered = 0;
        offer_limit = offer;
        @(posedge clk);
        #1;
        plan(a, b);
        start_in = 1'b1;
        start_addr_in = a[21:0];
        to_write_byte_in = b;
        src_en = 1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        if (b != 0) begin
            @(negedge clk);
            chk("busy_after_start", busy_out, 1);
        end
        wait_done(4000);
        src_en = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("input_queue_drained", exp_data.size(), 0);
        chk("done_count", dones_seen, 1);
        chk("busy_idle_after", busy_out, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_write"}, bus.ddr3_emif_write, 0);
        chk({tag, "_addr"}, bus.ddr3_emif_addr, 0);
        chk({tag, "_count"}, bus.ddr3_emif_burst_count, 0);
        chk({tag, "_data"}, bus.ddr3_emif_write_data, 0);
        chk({tag, "_be"}, bus.ddr3_emif_byte_enable, 0);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_done"}, done_out, 0);
        chk({tag, "_s_ready"}, bus.s_ready, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a;
        int unsigned b;
        int n;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.ddr3_emif_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: 1024 bytes at 0x100, full rate.
        run_xfer(32'h100, 1024, 32, 0, 100);
        chk("t1_bursts", obs_addr.size(), 2);
        if (obs_addr.size() == 2) begin
            chk("t1_addr0", obs_addr[0], 32'h100);
            chk("t1_cnt0", obs_cnt[0], 16);
            chk("t1_addr1", obs_addr[1], 32'h110);
            chk("t1_cnt1", obs_cnt[1], 16);
        end
        chk("t1_beats", beats_seen, 32);
        chk("t1_last_be", last_be, 32'hFFFF_FFFF);

        // 2: 100 bytes, a fifth word offered but refused.
        run_xfer(32'h40, 100, 5, 0, 100);
        chk("t2_bursts", obs_cnt.size(), 1);
        if (obs_cnt.size() == 1) chk("t2_cnt", obs_cnt[0], 4);
        chk("t2_beats", beats_seen, 4);
        chk("t2_last_be", last_be, 32'h0000_000F);
        chk("t2_accepted", acc_cnt, 4);

        // 3: zero bytes.
        clear_obs();
        plan(32'h55, 0);
        @(posedge clk);
        #1;
        start_in = 1'b1;
        start_addr_in = 22'h55;
        to_write_byte_in = 32'd0;
        @(negedge clk);
        chk("t3_done_not_yet", done_out, 0);
        @(posedge clk);
        #1;
        start_in = 1'b0;
        @(negedge clk);
        chk("t3_done_pulse", done_out, 1);
        chk("t3_busy", busy_out, 0);
        @(negedge clk);
        chk("t3_done_one_cycle", done_out, 0);
        chk("t3_busy_after", busy_out, 0);
        repeat (3) @(negedge clk);
        chk("t3_no_beats", beats_seen, 0);
        chk("t3_done_count", dones_seen, 1);

        // 4: 16-beat burst with ready toggling every 3 cycles.
        run_xfer(32'h1000, 512, 16, 1, 100);
        chk("t4_bursts", obs_cnt.size(), 1);
        if (obs_cnt.size() == 1) chk("t4_cnt", obs_cnt[0], 16);
        chk("t4_beats", beats_seen, 16);

        // 5: address wrap.
        run_xfer(32'h3FFFF8, 768, 24, 0, 100);
        chk("t5_bursts", obs_addr.size(), 2);
        if (obs_addr.size() == 2) begin
            chk("t5_addr0", obs_addr[0], 32'h3FFFF8);
            chk("t5_cnt0", obs_cnt[0], 16);
            chk("t5_addr1", obs_addr[1], 32'h000008);
            chk("t5_cnt1", obs_cnt[1], 8);
        end

        // 6: reset mid-burst, then a clean short transfer.
        clear_obs();
        rmode = 0;
        vprob = 100;
        offered = 0;
        offer_limit = 32;
        @(posedge clk);
        #1;
        plan(32'h200, 1024);
        start_in = 1'b1;
        start_addr_in = 22'h200;
        to_write_byte_in = 32'd1024;
        src_en = 1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        n = 0;
        while (beats_seen < 5 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("t6_reached_beat5", beats_seen >= 5, 1);
        #1;
        src_en = 0;
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        flush_model();
        #1;
        check_idle_outputs("t6_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_xfer(32'h40, 64, 2, 0, 100);
        chk("t6_beats", beats_seen, 2);
        chk("t6_bursts", obs_cnt.size(), 1);
        if (obs_cnt.size() == 1) chk("t6_cnt", obs_cnt[0], 2);

        // Randomised transfers with random valid and ready.
        for (int k = 0; k < 6; k++) begin
            a = int'($urandom & 32'h3F_FFFF);
            b = $urandom_range(1, 1500);
            run_xfer(a, b, int'((b + 31) / 32), 2, 60);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr3_frame_writer.md
Name: ddr3_frame_writer

Overview:
Upstream stage of the DDR3 read path. It accepts 256-bit frame words from the host-side loader over a valid/ready stream and buffers them in a small FIFO. It issues Avalon-MM burst writes into DDR3 starting at a controller-supplied word address, and signals completion to the controller, which then starts the DDR3 read/display chain.

Parameters:
DATA_W, 256, stream and EMIF data width in bits
ADDR_W, 22, EMIF word-address width
MAX_BURST, 16, maximum Avalon burst length in beats (must be ≤ 16; burst count port is 5 bits)
FIFO_DEPTH, 32, staging FIFO depth in words (power of 2, ≥ MAX_BURST)

Ports:
clk  in  1  memory-side clock (same clock as EMIF user interface)
rst_n  in  1  asynchronous active-low reset
start_in  in  1  one-cycle pulse; latches start_addr_in and to_write_byte_in
start_addr_in  in  ADDR_W  first DDR3 word address
to_write_byte_in  in  32  byte count to write
busy_out  out  1  high from accepted start until done
done_out  out  1  one-cycle pulse when the final beat is accepted by the EMIF
s_data  in  DATA_W  input word, byte 0 in bits [7:0]
s_valid  in  1  input word valid
s_ready  out  1  writer accepts s_data this cycle when s_valid && s_ready
ddr3_emif_ready  in  1  EMIF ready (inverse waitrequest)
ddr3_emif_write  out  1  write request/beat valid
ddr3_emif_addr  out  ADDR_W  burst start word address
ddr3_emif_write_data  out  DATA_W  beat data
ddr3_emif_byte_enable  out  DATA_W/8  beat byte enables
ddr3_emif_burst_count  out  5  burst length, valid on the first beat

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE, FIFO is flushed, counters are cleared. A reset mid-burst abandons the burst immediately; no completion pulse.
- Word total: total_words = ceil(bytes/32), computed with a 27-bit result.
- Last-word byte enables: if bytes%32 = r ≠ 0, the last beat's byte_enable has bits [r-1:0] = 1 and the rest 0. All other beats have enable = all ones.
- start_in while busy_out = 1 is ignored.
- FSM IDLE:
  - On start_in with bytes = 0: go to DONE (done_out pulses the next cycle, no writes).
  - On start_in otherwise: busy_out = 1 next cycle, go to WAIT_DATA.
- FSM WAIT_DATA:
  - burst_len = min(MAX_BURST, remaining_words).
  - When FIFO level ≥ burst_len, go to BURST. The burst's data is fully buffered before the first beat.
- FSM BURST:
  - ddr3_emif_write = 1 for each beat, with data from the FIFO head.
  - addr and burst_count are presented on the first beat. They are held, along with all outputs, while ddr3_emif_ready = 0.
  - A beat completes when write && ready; the FIFO pops on the same edge.
  - After the final beat of the burst: address += burst_len (mod 2^ADDR_W, wraps silently) and remaining -= burst_len. Go to DONE if remaining = 0, else to WAIT_DATA.
  - Between bursts, write deasserts for at least one cycle.
- FSM DONE: done_out = 1 for one cycle, busy_out drops the same cycle, go to IDLE.
- s_ready = (state ≠ IDLE) && !fifo_full && (accepted_words < total_words).
  - Words beyond total are not accepted.
  - Input is never accepted in IDLE.
- A FIFO push and pop in the same cycle leaves the level unchanged. Full and empty are exact.
- Throughput: back-to-back beats at 1 word/clk when ready is held high.

Decomposition:
- Shared package wps_pkg:
  - EMIF widths: DATA_W, BE_W = DATA_W/8, ADDR_W, BURST_W = 5.
  - BYTES_PER_WORD = 32.
  - FSM state encoding.
- Sub-module sync_fifo_fwft:
  - Single-clock first-word-fall-through FIFO with level output.
  - Parameters DEPTH and WIDTH.
  - Async active-low reset.

Test Plan:
1. start addr=0x000100, bytes=1024 (32 words), stream at full rate, ready=1 → two bursts: addr 0x100 with count 16, then addr 0x110 with count 16. 32 beats, all byte_enable=0xFFFFFFFF; done_out pulses once.
2. bytes=100 → 4 words. One burst with count 4; the last beat's byte_enable = 0x0000000F. The fifth offered word is not accepted (s_ready=0).
3. bytes=0 → done_out pulses 1 cycle after start; ddr3_emif_write never asserts; busy_out stays low except that window.
4. ready toggles 0/1 every 3 cycles during a 16-beat burst → data, addr and count are held stable while ready=0. The beat order matches input order exactly (scoreboard compare).
5. addr=0x3FFFF8, bytes=768 (24 words) → bursts at 0x3FFFF8 (16) and 0x000008 (8), wrapping modulo 2^22.
6. Reset asserted mid-burst after beat 5 → outputs return to 0 immediately. A subsequent start with bytes=64 completes with 2 clean beats and no stale FIFO data.
